wb_write_port_ctrl: RTL and testbench
=====================================

// Module: wb_write_port_ctrl
// PURPOSE
//  Write-side controller for the 32x32 register file's single write port (WB_WE/WB_REG/WB_DATA).
//  Merges ALU results (single-cycle, never stalled) with LSU load results (late, back-pressured).
//  Buffers LSU results in a small FIFO and tracks outstanding loads in a pending scoreboard.
//  Drives RS_STALL and same-cycle forwarding to the decode/read stage.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register index width (x0..x31)
//  FIFO_DEPTH  4   LSU write-back buffer entries (power of 2, >=2)
// PORTS
//  CLK         in   1       clock, rising edge
//  RESET_N     in   1       asynchronous, active-low reset
//  ALU_VALID   in   1       ALU result valid this cycle (always accepted)
//  ALU_RD      in   ADDR_W  ALU destination register
//  ALU_DATA    in   DATA_W  ALU result
//  LSU_VALID   in   1       load result offered
//  LSU_RD      in   ADDR_W  load destination register
//  LSU_DATA    in   DATA_W  load data
//  LSU_READY   out  1       load result accepted when LSU_VALID&&LSU_READY
//  ISSUE_VALID in   1       load issued to LSU this cycle
//  ISSUE_RD    in   ADDR_W  destination of the issued load
//  ISSUE_STALL out  1       pending[ISSUE_RD] set (core must hold issue)
//  RS1, RS2    in   ADDR_W  source registers being read this cycle
//  RS_STALL    out  1       RS1 or RS2 (non-zero) pending and not forwarded
//  FWD1_HIT    out  1       WB_WE && WB_REG==RS1 && RS1!=0
//  FWD2_HIT    out  1       same for RS2
//  WB_WE       out  1       register file WRITE_ENABLE (registered)
//  WB_REG      out  ADDR_W  register file WRITE_REG (registered)
//  WB_DATA     out  DATA_W  register file DATA_IN (registered); also forwarding data
//  PENDING     out  32      scoreboard vector, bit i = load to xi outstanding
//  FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  buffered LSU entries
// BEHAVIOUR
//  Reset: WB_WE=0, WB_REG=0, WB_DATA=0, PENDING=0, FIFO empty (count 0); LSU_READY=1 after release.
//  Reset mid-operation flushes FIFO and scoreboard; in-flight loads are discarded.
//  Per-cycle write-port source selection (priority), result registered into WB_* at edge:
//   1. ALU_VALID && ALU_RD!=0        -> ALU; LSU accepted this cycle is pushed to FIFO
//   2. FIFO not empty                -> pop head; accepted LSU pushed (push+pop: count unchanged)
//   3. FIFO empty && LSU accept && LSU_RD!=0 -> LSU bypass, latency 1, no push
//   4. otherwise WB_WE<=0 (WB_REG/WB_DATA hold)
//  ALU_VALID with ALU_RD=0: ignored. LSU with LSU_RD=0: accepted and dropped, never queued.
//  LSU_READY = (FIFO_COUNT < FIFO_DEPTH); a same-cycle pop does not raise it (conservative).
//  FIFO strictly in order; ALU may starve FIFO indefinitely (back-pressure via LSU_READY).
//  Scoreboard: ISSUE_VALID && ISSUE_RD!=0 sets PENDING[ISSUE_RD] at edge.
//   Bit cleared at the edge an LSU entry for that reg is loaded into WB_* (bypass or pop).
//   Set and clear on the same reg in the same cycle: set wins.
//   ALU write to a pending reg does not clear it. ISSUE_VALID while ISSUE_STALL is a protocol error.
//  Forwarding: regfile updates at the edge after WB_*; during that cycle FWDx_HIT flags WB_DATA.
//  RS_STALL = (RS1!=0 && PENDING[RS1] && !FWD1_HIT) || (RS2!=0 && PENDING[RS2] && !FWD2_HIT).
//  Stall and forward outputs are combinational from registered state plus RS1/RS2/ISSUE_RD.
// STRUCTURE
//  Package wb_pkg: DATA_W/ADDR_W constants, typedef struct packed {logic [ADDR_W-1:0] rd;
//   logic [DATA_W-1:0] data;} wb_entry_t, typedef enum {SRC_NONE,SRC_ALU,SRC_FIFO,SRC_LSU} wb_src_t.
//  Sub-module wb_fifo: sync FIFO of wb_entry_t, push/pop/full/empty/count, async reset.
//  Top level: source-select mux, WB_* registers, 32-bit scoreboard, stall/forward logic.
// TESTING
//  Reset with LSU_VALID/ALU_VALID high -> WB_WE=0, PENDING=0, FIFO_COUNT=0 throughout reset.
//  ALU_VALID rd=5 data=0x1234 -> next cycle WB_WE=1 WB_REG=5 WB_DATA=0x1234; rd=0 -> WB_WE=0.
//  ISSUE rd=7; LSU rd=7 data=0xDEAD while ALU rd=3 -> cycle+1 WB x3, cycle+2 WB x7 0xDEAD;
//   PENDING[7] clears at cycle+2, FIFO_COUNT peaks at 1.
//  ALU every cycle, 5 LSU offers -> 4 accepted, LSU_READY=0 on 5th; ALU stops -> 4 pops in order.
//  PENDING[9]=1, RS1=9 -> RS_STALL=1; in the cycle WB_REG=9 -> FWD1_HIT=1, RS_STALL=0.
//  ISSUE rd=4 in same cycle that x4 load is written back -> PENDING[4] stays 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port controller.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_LSU
    } wb_src_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [ADDR_W-1:0] r);
        reg_mask    = '0;
        reg_mask[r] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for LSU write-back entries that lost arbitration.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_port_ctrl.sv
// Arbitrates ALU and LSU results onto the single register-file write port,
// tracks outstanding loads and produces read-stage stall/forward indications.
module wb_write_port_ctrl
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                ALU_VALID,
    input  logic [ADDR_W-1:0]   ALU_RD,
    input  logic [DATA_W-1:0]   ALU_DATA,
    input  logic                LSU_VALID,
    input  logic [ADDR_W-1:0]   LSU_RD,
    input  logic [DATA_W-1:0]   LSU_DATA,
    output logic                LSU_READY,
    input  logic                ISSUE_VALID,
    input  logic [ADDR_W-1:0]   ISSUE_RD,
    output logic                ISSUE_STALL,
    input  logic [ADDR_W-1:0]   RS1,
    input  logic [ADDR_W-1:0]   RS2,
    output logic                RS_STALL,
    output logic                FWD1_HIT,
    output logic                FWD2_HIT,
    output logic                WB_WE,
    output logic [ADDR_W-1:0]   WB_REG,
    output logic [DATA_W-1:0]   WB_DATA,
    output logic [NUM_REGS-1:0] PENDING,
    output logic [CNT_W-1:0]    FIFO_COUNT
);

    wb_src_t             wb_src;
    wb_entry_t           fifo_head;
    wb_entry_t           lsu_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic                alu_sel;
    logic                lsu_take;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    assign lsu_entry = '{rd: LSU_RD, data: LSU_DATA};
    assign LSU_READY = !fifo_full;
    assign alu_sel   = ALU_VALID && (ALU_RD != '0);
    // Loads to x0 are still handshaken so the LSU can retire them, but go nowhere.
    assign lsu_take  = LSU_VALID && LSU_READY && (LSU_RD != '0);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .push       (fifo_push),
        .push_entry (lsu_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (FIFO_COUNT)
    );

    always_comb begin
        wb_src   = SRC_NONE;
        clr_mask = '0;
        set_mask = '0;
        if (alu_sel) begin
            wb_src = SRC_ALU;
        end else if (!fifo_empty) begin
            wb_src = SRC_FIFO;
        end else if (lsu_take) begin
            wb_src = SRC_LSU;
        end
        fifo_push = lsu_take && (wb_src != SRC_LSU);
        fifo_pop  = (wb_src == SRC_FIFO);
        if (wb_src == SRC_FIFO) begin
            clr_mask = reg_mask(fifo_head.rd);
        end else if (wb_src == SRC_LSU) begin
            clr_mask = reg_mask(LSU_RD);
        end
        if (ISSUE_VALID && (ISSUE_RD != '0)) begin
            set_mask = reg_mask(ISSUE_RD);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WB_WE   <= 1'b0;
            WB_REG  <= '0;
            WB_DATA <= '0;
            PENDING <= '0;
        end else begin
            case (wb_src)
                SRC_ALU: begin
                    WB_WE   <= 1'b1;
                    WB_REG  <= ALU_RD;
                    WB_DATA <= ALU_DATA;
                end
                SRC_FIFO: begin
                    WB_WE   <= 1'b1;
                    WB_REG  <= fifo_head.rd;
                    WB_DATA <= fifo_head.data;
                end
                SRC_LSU: begin
                    WB_WE   <= 1'b1;
                    WB_REG  <= LSU_RD;
                    WB_DATA <= LSU_DATA;
                end
                default: begin
                    WB_WE   <= 1'b0;
                end
            endcase
            // A new issue to the same register outranks the retiring load.
            PENDING <= (PENDING & ~clr_mask) | set_mask;
        end
    end

    assign ISSUE_STALL = PENDING[ISSUE_RD];
    assign FWD1_HIT    = WB_WE && (WB_REG == RS1) && (RS1 != '0);
    assign FWD2_HIT    = WB_WE && (WB_REG == RS2) && (RS2 != '0);
    assign RS_STALL    = ((RS1 != '0) && PENDING[RS1] && !FWD1_HIT) ||
                         ((RS2 != '0) && PENDING[RS2] && !FWD2_HIT);

endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// Directed self-checking bench for wb_write_port_ctrl.
module tb_wb_write_port_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        LSU_VALID;
    logic [4:0]  LSU_RD;
    logic [31:0] LSU_DATA;
    logic        LSU_READY;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic        ISSUE_STALL;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic        RS_STALL;
    logic        FWD1_HIT;
    logic        FWD2_HIT;
    logic        WB_WE;
    logic [4:0]  WB_REG;
    logic [31:0] WB_DATA;
    logic [31:0] PENDING;
    logic [2:0]  FIFO_COUNT;

    int tests_run    = 0;
    int tests_failed = 0;

    wb_write_port_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ALU_VALID   (ALU_VALID),
        .ALU_RD      (ALU_RD),
        .ALU_DATA    (ALU_DATA),
        .LSU_VALID   (LSU_VALID),
        .LSU_RD      (LSU_RD),
        .LSU_DATA    (LSU_DATA),
        .LSU_READY   (LSU_READY),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_RD    (ISSUE_RD),
        .ISSUE_STALL (ISSUE_STALL),
        .RS1         (RS1),
        .RS2         (RS2),
        .RS_STALL    (RS_STALL),
        .FWD1_HIT    (FWD1_HIT),
        .FWD2_HIT    (FWD2_HIT),
        .WB_WE       (WB_WE),
        .WB_REG      (WB_REG),
        .WB_DATA     (WB_DATA),
        .PENDING     (PENDING),
        .FIFO_COUNT  (FIFO_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic alu_v, input logic [4:0] alu_r, input logic [31:0] alu_d,
                                 input logic lsu_v, input logic [4:0] lsu_r, input logic [31:0] lsu_d,
                                 input logic iss_v, input logic [4:0] iss_r);
        ALU_VALID   = alu_v;
        ALU_RD      = alu_r;
        ALU_DATA    = alu_d;
        LSU_VALID   = lsu_v;
        LSU_RD      = lsu_r;
        LSU_DATA    = lsu_d;
        ISSUE_VALID = iss_v;
        ISSUE_RD    = iss_r;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        RS1 = '0;
        RS2 = '0;
        RESET_N = 1'b0;
        applyStimulus(1, 5, 32'h1111, 1, 6, 32'h2222, 1, 8);

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_we", WB_WE, 0);
            checkOutput("rst_pending", PENDING, 0);
            checkOutput("rst_count", FIFO_COUNT, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        RESET_N = 1'b1;
        #1;
        checkOutput("rst_ready", LSU_READY, 1);
        checkOutput("rst_reg", WB_REG, 0);
        checkOutput("rst_data", WB_DATA, 0);

        applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu_we", WB_WE, 1);
        checkOutput("alu_reg", WB_REG, 5);
        checkOutput("alu_data", WB_DATA, 32'h1234);
        applyStimulus(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu_x0_we", WB_WE, 0);
        checkOutput("alu_x0_reg_hold", WB_REG, 5);
        checkOutput("alu_x0_data_hold", WB_DATA, 32'h1234);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
        tick();
        checkOutput("issue7_pending", PENDING[7], 1);
        checkOutput("issue7_stall", ISSUE_STALL, 1);
        applyStimulus(1, 3, 32'h33, 1, 7, 32'hDEAD, 0, 0);
        #1;
        checkOutput("merge_ready", LSU_READY, 1);
        tick();
        checkOutput("merge_alu_reg", WB_REG, 3);
        checkOutput("merge_alu_data", WB_DATA, 32'h33);
        checkOutput("merge_count", FIFO_COUNT, 1);
        checkOutput("merge_pend_held", PENDING[7], 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("merge_pop_we", WB_WE, 1);
        checkOutput("merge_pop_reg", WB_REG, 7);
        checkOutput("merge_pop_data", WB_DATA, 32'hDEAD);
        checkOutput("merge_pend_clr", PENDING[7], 0);
        checkOutput("merge_count_0", FIFO_COUNT, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10);
        tick();
        applyStimulus(0, 0, 0, 1, 10, 32'hBEEF, 0, 0);
        tick();
        checkOutput("bypass_reg", WB_REG, 10);
        checkOutput("bypass_data", WB_DATA, 32'hBEEF);
        checkOutput("bypass_count", FIFO_COUNT, 0);
        checkOutput("bypass_pending", PENDING, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h5555, 0, 0);
        tick();
        checkOutput("lsu_x0_we", WB_WE, 0);
        checkOutput("lsu_x0_count", FIFO_COUNT, 0);

        // ALU hogs the port while five loads are offered; only four fit.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, k, 1, 5'(11 + k), 32'hA0 + k, 0, 0);
            #1;
            checkOutput("fill_ready", LSU_READY, (k < 4) ? 1 : 0);
            tick();
            checkOutput("fill_count", FIFO_COUNT, (k < 4) ? k + 1 : 4);
            checkOutput("fill_alu_reg", WB_REG, 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("drain0_reg", WB_REG, 11);
        checkOutput("drain0_data", WB_DATA, 32'hA0);
        checkOutput("drain0_count", FIFO_COUNT, 3);
        applyStimulus(0, 0, 0, 1, 16, 32'hB0, 0, 0);
        #1;
        checkOutput("drain1_ready", LSU_READY, 1);
        tick();
        checkOutput("drain1_reg", WB_REG, 12);
        checkOutput("drain1_data", WB_DATA, 32'hA1);
        checkOutput("drain1_pushpop_count", FIFO_COUNT, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("drain2_reg", WB_REG, 13);
        checkOutput("drain2_count", FIFO_COUNT, 2);
        tick();
        checkOutput("drain3_reg", WB_REG, 14);
        checkOutput("drain3_data", WB_DATA, 32'hA3);
        tick();
        checkOutput("drain4_reg", WB_REG, 16);
        checkOutput("drain4_data", WB_DATA, 32'hB0);
        checkOutput("drain4_count", FIFO_COUNT, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        RS1 = 9;
        #1;
        checkOutput("rs1_stall", RS_STALL, 1);
        checkOutput("rs1_nofwd", FWD1_HIT, 0);
        applyStimulus(1, 9, 32'h77, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu9_pend_kept", PENDING[9], 1);
        checkOutput("alu9_fwd1", FWD1_HIT, 1);
        checkOutput("alu9_fwd1_nostall", RS_STALL, 0);
        RS1 = 0;
        RS2 = 9;
        #1;
        checkOutput("alu9_fwd2", FWD2_HIT, 1);
        checkOutput("alu9_fwd1_x0", FWD1_HIT, 0);
        checkOutput("alu9_fwd2_nostall", RS_STALL, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("idle_fwd2", FWD2_HIT, 0);
        checkOutput("idle_rs2_stall", RS_STALL, 1);
        applyStimulus(0, 0, 0, 1, 9, 32'h99, 0, 0);
        tick();
        checkOutput("load9_data", WB_DATA, 32'h99);
        checkOutput("load9_pend_clr", PENDING[9], 0);
        checkOutput("load9_nostall", RS_STALL, 0);
        RS2 = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
        tick();
        applyStimulus(0, 0, 0, 1, 4, 32'h44, 1, 4);
        tick();
        checkOutput("setwins_reg", WB_REG, 4);
        checkOutput("setwins_data", WB_DATA, 32'h44);
        checkOutput("setwins_pending", PENDING[4], 1);

        applyStimulus(1, 1, 32'h11, 1, 20, 32'h2020, 1, 21);
        tick();
        checkOutput("pre_rst_count", FIFO_COUNT, 1);
        checkOutput("pre_rst_pending", PENDING, 32'h0020_0010);
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_count", FIFO_COUNT, 0);
        checkOutput("mid_rst_pending", PENDING, 0);
        checkOutput("mid_rst_we", WB_WE, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        checkOutput("post_rst_count", FIFO_COUNT, 0);
        checkOutput("post_rst_we", WB_WE, 0);
        checkOutput("post_rst_ready", LSU_READY, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
